// File: rtl/audio_rx_pkg.sv
// Shared types and helpers for the I2S receive path.
package audio_rx_pkg;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } rx_state_e;

  localparam int SYNC_STAGES = 2;
  localparam int CH_LEFT     = 0;
  localparam int CH_RIGHT    = 1;

  // Bit offset of a lane/channel sample inside the packed frame word.
  function automatic int slice_off(input int lane, input int ch, input int width);
    return (2 * lane + ch) * width;
  endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO; the head entry is held in a register so the
// output word stays put while the consumer stalls.
module audio_frame_fifo #(
  parameter int WIDTH_BITS = 128,
  parameter int DEPTH      = 4
) (
  input  logic                       ck_i,
  input  logic                       rst_n_i,
  input  logic                       push_i,
  input  logic [WIDTH_BITS-1:0]      push_data_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic [WIDTH_BITS-1:0]      head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [WIDTH_BITS-1:0] head_q, head_d;
  logic                  do_pop, do_push;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = head_q;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (do_push && (wr_ptr_q == rd_ptr_d)) head_d = push_data_i;
    else                                   head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge ck_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/i2s_rx_framer.sv
// I2S multi-lane receiver: oversamples sck/ws/sd in the ck domain, deserializes
// stereo frames per lane and queues them for the audio engine.
//   state     | meaning
//   SYNC_WAIT | unaligned or disabled, waiting for a ws 1->0 boundary
//   LEFT      | collecting left-channel bits
//   RIGHT     | collecting right-channel bits; ws 1->0 completes the frame
module i2s_rx_framer
  import audio_rx_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int DEPTH = 4
) (
  input  logic                       ck,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       sck,
  input  logic                       ws,
  input  logic [LANES-1:0]           sd_in,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [2*LANES*WIDTH-1:0]   frame_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       locked,
  output logic                       overrun,
  input  logic                       clr_overrun
);

  localparam int FW = 2 * LANES * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  logic [SYNC_STAGES-1:0]            sck_sync_q;
  logic [SYNC_STAGES-1:0]            ws_sync_q;
  logic [SYNC_STAGES-1:0][LANES-1:0] sd_sync_q;
  logic                              sck_prev_q, ws_prev_q;
  logic                              sck_s, ws_s;
  logic [LANES-1:0]                  sd_s;
  logic                              rise, ws_tr;

  rx_state_e                         state_q;
  logic [CW-1:0]                     cnt_q;
  logic [LANES-1:0][WIDTH-1:0]       sh_q, hold_l_q;
  logic [FW-1:0]                     frame_q;
  logic                              push_q, locked_q, overrun_q;

  logic                              take_bit;
  logic [CW-1:0]                     cnt_inc;
  logic [LANES-1:0][WIDTH-1:0]       sh_nxt, just;
  logic [FW-1:0]                     frame_d;
  logic                              fifo_full, fifo_empty, drop;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q <= '0;
      ws_sync_q  <= '0;
      sd_sync_q  <= '0;
      sck_prev_q <= 1'b0;
      ws_prev_q  <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      ws_sync_q  <= {ws_sync_q[SYNC_STAGES-2:0], ws};
      sd_sync_q  <= {sd_sync_q[SYNC_STAGES-2:0], sd_in};
      sck_prev_q <= sck_s;
      if (rise) ws_prev_q <= ws_s;
    end
  end

  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign ws_s  = ws_sync_q[SYNC_STAGES-1];
  assign sd_s  = sd_sync_q[SYNC_STAGES-1];
  assign rise  = sck_s && !sck_prev_q;
  assign ws_tr = rise && (ws_s != ws_prev_q);

  // Bits past WIDTH are dropped; short slots are left-justified with zero LSBs.
  always_comb begin
    take_bit = (cnt_q < WIDTH_C);
    cnt_inc  = take_bit ? cnt_q + CW'(1) : cnt_q;
    sh_nxt   = sh_q;
    just     = '0;
    frame_d  = '0;
    for (int n = 0; n < LANES; n++) begin
      if (take_bit) sh_nxt[n] = {sh_q[n][WIDTH-2:0], sd_s[n]};
      just[n] = sh_nxt[n] << (WIDTH_C - cnt_inc);
      frame_d[slice_off(n, CH_LEFT, WIDTH)  +: WIDTH] = hold_l_q[n];
      frame_d[slice_off(n, CH_RIGHT, WIDTH) +: WIDTH] = just[n];
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SYNC_WAIT;
      cnt_q    <= '0;
      sh_q     <= '0;
      hold_l_q <= '0;
      frame_q  <= '0;
      push_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      push_q <= 1'b0;
      case (state_q)
        SYNC_WAIT: begin
          locked_q <= 1'b0;
          if (en && rise && ws_prev_q && !ws_s) begin
            state_q  <= LEFT;
            locked_q <= 1'b1;
            cnt_q    <= '0;
            sh_q     <= '0;
          end
        end
        LEFT, RIGHT: begin
          if (!en) begin
            state_q  <= SYNC_WAIT;
            locked_q <= 1'b0;
            cnt_q    <= '0;
            sh_q     <= '0;
          end else if (ws_tr) begin
            cnt_q <= '0;
            sh_q  <= '0;
            if (state_q == LEFT) begin
              hold_l_q <= just;
              state_q  <= RIGHT;
            end else begin
              frame_q  <= frame_d;
              push_q   <= 1'b1;
              state_q  <= LEFT;
            end
          end else if (rise) begin
            sh_q  <= sh_nxt;
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q  <= SYNC_WAIT;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign drop = push_q && fifo_full && !(frame_valid && frame_ready);

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n)           overrun_q <= 1'b0;
    else if (drop)        overrun_q <= 1'b1;
    else if (clr_overrun) overrun_q <= 1'b0;
  end

  audio_frame_fifo #(
    .WIDTH_BITS(FW),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .ck_i       (ck),
    .rst_n_i    (rst_n),
    .push_i     (push_q),
    .push_data_i(frame_q),
    .pop_i      (frame_ready),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level),
    .head_o     (frame_data)
  );

  assign frame_valid = !fifo_empty;
  assign locked      = locked_q;
  assign overrun     = overrun_q;

endmodule
